// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, instruction size, fetch FSM states
// and the reset PC used by the IF/ID and PC-related blocks.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: redirect and stall controls from later stages, the
// byte-wide memory read port, and the instruction presented to IF/ID.
interface if_fetch_if;
  import riscv_pkg::*;

  logic            stall;
  logic            jump;
  logic [XLEN-1:0] jump_addr;
  logic            mem_busy;
  logic [7:0]      mem_rdata;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_is;
  logic            if_valid;

  modport master (
    input  stall, jump, jump_addr, mem_busy, mem_rdata,
    output mem_req, mem_addr, if_pc, if_is, if_valid
  );

  modport slave (
    output stall, jump, jump_addr, mem_busy, mem_rdata,
    input  mem_req, mem_addr, if_pc, if_is, if_valid
  );

endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each 32-bit instruction from four little-endian
// byte reads and holds it for IF/ID until accepted or redirected.
module if_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic       clk,
  input  logic       rst,
  if_fetch_if.master bus
);

  localparam logic [2:0]      NBYTES = 3'(INST_BYTES);
  localparam logic [XLEN-1:0] PC_INC = XLEN'(INST_BYTES);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] is_buf_q, is_buf_d;
  logic [XLEN-1:0] if_is_q, if_is_d;
  logic [2:0]      ic_q, ic_d;
  logic [2:0]      rc_q, rc_d;
  logic            pend_q, pend_d;
  logic            valid_q, valid_d;

  logic issue;
  logic accept;

  assign bus.mem_req  = !rst && (state_q == FETCH) && (ic_q < NBYTES);
  assign bus.mem_addr = pc_q + XLEN'(ic_q);

  // A redirect suppresses the issue so the old stream never advances ic.
  assign issue  = bus.mem_req && !bus.mem_busy && !bus.jump;
  assign accept = valid_q && !bus.stall;

  assign bus.if_pc    = pc_q;
  assign bus.if_is    = if_is_q;
  assign bus.if_valid = valid_q;

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    is_buf_d = is_buf_q;
    if_is_d  = if_is_q;
    ic_d     = ic_q;
    rc_d     = rc_q;
    pend_d   = issue;
    valid_d  = valid_q;

    if (issue) begin
      ic_d = ic_q + 3'd1;
    end

    if (pend_q) begin
      is_buf_d[{rc_q[1:0], 3'b000} +: 8] = bus.mem_rdata;
      rc_d = rc_q + 3'd1;
      if (rc_q == NBYTES - 3'd1) begin
        if_is_d = is_buf_d;
        valid_d = 1'b1;
        state_d = HOLD;
      end
    end

    if (accept) begin
      pc_d    = pc_q + PC_INC;
      ic_d    = '0;
      rc_d    = '0;
      valid_d = 1'b0;
      state_d = FETCH;
    end

    // Redirect wins over a same-edge receive or accept; pend is cleared so
    // the byte still in flight from the old stream is discarded.
    if (bus.jump) begin
      pc_d    = {bus.jump_addr[XLEN-1:2], 2'b00};
      ic_d    = '0;
      rc_d    = '0;
      pend_d  = 1'b0;
      valid_d = 1'b0;
      state_d = FETCH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      is_buf_q <= '0;
      if_is_q  <= '0;
      ic_q     <= '0;
      rc_q     <= '0;
      pend_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      is_buf_q <= is_buf_d;
      if_is_q  <= if_is_d;
      ic_q     <= ic_d;
      rc_q     <= rc_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage of the RISC-V core. It keeps the program counter and reads each 32-bit instruction from the 8-bit unified memory port as four little-endian byte reads. It presents the assembled instruction and its PC to the IF/ID pipeline register under a valid/stall handshake, and it redirects on jumps and branches from later stages.

## Interface
- RESET_PC, 32'h00000000, PC loaded on reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall_i  in  1  downstream cannot accept; hold the current instruction
- jump_i  in  1  redirect request from EX; highest priority after rst
- jump_addr_i  in  32  redirect target; bits [1:0] ignored and forced to 0
- mem_busy_i  in  1  memory port taken by load/store this cycle; no fetch issue
- mem_rdata_i  in  8  read data for the byte issued in the previous cycle
- mem_req_o  out  1  fetch read request this cycle (combinational)
- mem_addr_o  out  32  byte address of the request (combinational)
- if_pc_o  out  32  PC of the presented instruction
- if_is_o  out  32  presented instruction word
- if_valid_o  out  1  if_pc_o/if_is_o hold a complete instruction

## Operation
- Registers:
  - pc[31:0]
  - is_buf[31:0]
  - ic[2:0]: bytes issued, 0..4
  - rc[2:0]: bytes received, 0..4
  - pend: a byte was issued last cycle
  - state: FETCH or HOLD
- Requests, combinational: mem_req_o = !rst && state==FETCH && ic<4; mem_addr_o = pc + ic.
- An issue happens when mem_req_o && !mem_busy_i && !jump_i. On issue: ic++ and pend<=1; otherwise pend<=0.
- Receive: if pend, mem_rdata_i is written to is_buf[8*rc+7:8*rc] and rc++. Bytes are little-endian.
- On the receive with rc==3: if_is_o <= the completed word, if_valid_o <= 1, state <= HOLD.
- HOLD: no requests; outputs are held stable while stall_i=1.
- Accept at an edge where if_valid_o && !stall_i: pc <= pc+4, ic/rc <= 0, if_valid_o <= 0, state <= FETCH.
- Jump, at any edge with jump_i=1:
  - pc <= {jump_addr_i[31:2],2'b00}, ic/rc/pend <= 0, if_valid_o <= 0, state <= FETCH.
  - Any in-flight byte returning next cycle is discarded.
  - Jump overrides a same-cycle accept and a same-cycle receive.
- mem_busy_i stalls issue only. A byte issued in the previous cycle is still received.
- if_pc_o = pc. It is valid as a tag only while if_valid_o=1.
- Arithmetic: pc+4 and pc+ic wrap modulo 2^32 with no flag.

## Timing
- Reset values: pc=RESET_PC, if_is_o=0, if_valid_o=0, ic=rc=0, pend=0, state=FETCH. mem_req_o is 0 while rst is high.
- Memory read latency is 1 cycle: data for a request in cycle n appears on mem_rdata_i in cycle n+1.
- Fetch latency with no busy cycles: entering FETCH in cycle 0 issues bytes in cycles 0–3 and receives them in cycles 1–4. if_valid_o is 1 from cycle 5.
- Each busy cycle during issue adds one cycle.
- Throughput: one instruction per 6 cycles (accept edge, 4 issues, last receive).
- rst mid-fetch: all state returns to reset values at that edge. A byte returning afterwards is ignored because pend=0.
- A jump in the same cycle as the 4th receive: the word is dropped and if_valid_o stays 0.

## Structure
- Shared package riscv_pkg holds:
  - XLEN=32
  - INST_BYTES=4
  - fetch state enum {FETCH, HOLD}
  - RESET_PC default constant, shared with the IF/ID and PC-related blocks
- Single module. No sub-module is natural; the byte assembler is a few lines of the datapath.

## Test plan
- Reset release with memory bytes 0x13,0x05,0x00,0x00 at 0..3 -> mem_addr_o 0,1,2,3 in cycles 0–3; if_valid_o=1 in cycle 5 with if_is_o=32'h00000513, if_pc_o=0.
- stall_i held high 3 cycles after valid -> outputs unchanged, mem_req_o=0. Release -> next fetch starts at address 4.
- mem_busy_i high in cycle 1 -> address 1 issued in cycle 2; valid in cycle 6; word correct.
- jump_i in cycle 2 with jump_addr_i=32'h00001007 -> fetch restarts at 0x1004; the stale byte from the cycle-2 issue is not used; if_pc_o=0x1004 at valid.
- jump_i at the same edge as accept -> pc equals the jump target, not pc+4.
- rst asserted in cycle 3 of a fetch -> if_valid_o=0, next fetch from RESET_PC, word assembled from fresh bytes only.
